// File: rtl/lenet_pkg.sv
// Shared widths, window length and FSM state codes for the LeNet accumulate stage.
package lenet_pkg;
   localparam int PROD_W_DEF  = 16;
   localparam int ACC_W_DEF   = 24;
   localparam int OUT_W_DEF   = 8;
   localparam int SHIFT_DEF   = 8;
   localparam int MAX_LEN_DEF = 25;   // 5x5 kernel

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ACCUM = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;
endpackage

// File: rtl/lenet_sat_add.sv
// Unsigned saturating adder: wide accumulator operand plus narrower product.
module lenet_sat_add
   import lenet_pkg::*;
#(
   parameter int A_W = ACC_W_DEF,
   parameter int B_W = PROD_W_DEF
) (
   input  logic [A_W-1:0] a,
   input  logic [B_W-1:0] b,
   output logic [A_W-1:0] sum,
   output logic           ovf
);
   logic [A_W:0] sum_full;

   assign sum_full = {1'b0, a} + (A_W + 1)'(b);
   assign ovf      = sum_full[A_W];
   assign sum      = ovf ? {A_W{1'b1}} : sum_full[A_W-1:0];
endmodule

// File: rtl/lenet_dot_accum.sv
// Window accumulator: bias + products, saturating, with requantised 8-bit output.
// state    | meaning
// ST_IDLE  | waiting for first beat of a window (bias sampled here)
// ST_ACCUM | window open, adding products
// ST_HOLD  | result registered, waiting for consumer; input stalled
module lenet_dot_accum
   import lenet_pkg::*;
#(
   parameter int PROD_W  = PROD_W_DEF,
   parameter int ACC_W   = ACC_W_DEF,
   parameter int MAX_LEN = MAX_LEN_DEF,
   parameter int SHIFT   = SHIFT_DEF,
   parameter int OUT_W   = OUT_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PROD_W-1:0] in_prod,
   input  logic              in_last,
   input  logic [ACC_W-1:0]  in_bias,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_sum,
   output logic [OUT_W-1:0]  out_q,
   output logic              out_sat,
   output logic              out_err_len
);
   localparam int CNT_W = $clog2(MAX_LEN + 1);
   localparam logic [ACC_W-1:0] Q_MAX = ACC_W'((1 << OUT_W) - 1);

   logic [1:0]       state;
   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic             sat_flag;

   logic [ACC_W-1:0] add_a;
   logic [ACC_W-1:0] add_sum;
   logic             add_ovf;
   logic             accept;
   logic             done;
   logic             sat_nxt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [ACC_W-1:0] q_wide;
   logic [OUT_W-1:0] q_clamp;

   // One adder serves both the first beat (bias) and later beats (acc).
   assign add_a = (state == ST_IDLE) ? in_bias : acc;

   lenet_sat_add #(
      .A_W (ACC_W),
      .B_W (PROD_W)
   ) u_sat_add (
      .a   (add_a),
      .b   (in_prod),
      .sum (add_sum),
      .ovf (add_ovf)
   );

   assign in_ready = (state == ST_IDLE) || (state == ST_ACCUM);
   assign accept   = in_valid && in_ready;
   assign cnt_nxt  = (state == ST_IDLE) ? CNT_W'(1) : cnt + CNT_W'(1);
   assign done     = in_last || (cnt_nxt == CNT_W'(MAX_LEN));
   assign sat_nxt  = add_ovf || ((state == ST_ACCUM) && sat_flag);
   assign q_wide   = add_sum >> SHIFT;
   assign q_clamp  = (q_wide > Q_MAX) ? Q_MAX[OUT_W-1:0] : q_wide[OUT_W-1:0];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         acc         <= '0;
         cnt         <= '0;
         sat_flag    <= 1'b0;
         out_valid   <= 1'b0;
         out_sum     <= '0;
         out_q       <= '0;
         out_sat     <= 1'b0;
         out_err_len <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_ACCUM: begin
               if (accept) begin
                  acc      <= add_sum;
                  cnt      <= cnt_nxt;
                  sat_flag <= sat_nxt;
                  if (done) begin
                     state       <= ST_HOLD;
                     out_valid   <= 1'b1;
                     out_sum     <= add_sum;
                     out_q       <= q_clamp;
                     out_sat     <= sat_nxt;
                     out_err_len <= !in_last;
                  end else begin
                     state <= ST_ACCUM;
                  end
               end
            end
            ST_HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  acc       <= '0;
                  cnt       <= '0;
                  sat_flag  <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_lenet_dot_accum.sv
// Randomised bench for lenet_dot_accum against a plain-arithmetic window model.
module tb_lenet_dot_accum;
   localparam int  ACC_W   = 24;
   localparam int  PROD_W  = 16;
   localparam int  OUT_W   = 8;
   localparam int  MAX_LEN = 25;
   localparam longint ACC_MAX = (64'd1 << ACC_W) - 1;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [PROD_W-1:0] in_prod;
   logic              in_last;
   logic [ACC_W-1:0]  in_bias;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  out_sum;
   logic [OUT_W-1:0]  out_q;
   logic              out_sat;
   logic              out_err_len;

   int n_chk = 0;
   int n_bad = 0;
   int unsigned wq[$];

   always #5 clk = ~clk;

   lenet_dot_accum dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_prod     (in_prod),
      .in_last     (in_last),
      .in_bias     (in_bias),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_sum     (out_sum),
      .out_q       (out_q),
      .out_sat     (out_sat),
      .out_err_len (out_err_len)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one beat and hold it until the DUT takes it (bounded).
   task automatic drive_beat(input logic [PROD_W-1:0] p, input logic l, input logic [ACC_W-1:0] b);
      bit rdy;
      bit taken = 1'b0;
      in_valid = 1'b1;
      in_prod  = p;
      in_last  = l;
      in_bias  = b;
      for (int k = 0; k < 40 && !taken; k++) begin
         rdy = in_ready;
         tick();
         taken = rdy;
      end
      if (!taken) chk("beat_timeout", 32'(taken), 32'd1);
   endtask

   // Sends the window in wq, then checks the result against the model.
   task automatic run_window(input logic [ACC_W-1:0] bias, input bit last_flag, input int hold_d);
      longint total;
      logic [ACC_W-1:0] e_sum;
      logic [OUT_W-1:0] e_q;
      bit e_sat;
      int n = wq.size();
      total = bias;
      foreach (wq[i]) total += wq[i];
      e_sat = total > ACC_MAX;
      e_sum = e_sat ? ACC_MAX[ACC_W-1:0] : total[ACC_W-1:0];
      e_q   = ((e_sum >> 8) > 255) ? 8'hFF : 8'(e_sum >> 8);

      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            in_prod  = 16'($urandom);
            in_last  = 1'($urandom);
            repeat ($urandom_range(1, 2)) tick();
         end
         drive_beat(16'(wq[i]), (i == n - 1) && last_flag,
                    (i == 0) ? bias : 24'($urandom));
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      chk("valid_lat", 32'(out_valid), 32'd1);
      chk("sum", 32'(out_sum), 32'(e_sum));
      chk("q", 32'(out_q), 32'(e_q));
      chk("sat", 32'(out_sat), 32'(e_sat));
      chk("err_len", 32'(out_err_len), 32'(!last_flag));
      for (int k = 0; k < hold_d; k++) begin
         in_valid = 1'($urandom);
         in_prod  = 16'($urandom);
         in_last  = 1'($urandom);
         tick();
         chk("hold_valid", 32'(out_valid), 32'd1);
         chk("hold_ready", 32'(in_ready), 32'd0);
         chk("hold_sum", 32'(out_sum), 32'(e_sum));
         chk("hold_q", 32'(out_q), 32'(e_q));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("hs_valid", 32'(out_valid), 32'd0);
      chk("hs_ready", 32'(in_ready), 32'd1);
      chk("hs_sum_keep", 32'(out_sum), 32'(e_sum));
      wq.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [ACC_W-1:0] b;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_prod   = '0;
      in_last   = 1'b0;
      in_bias   = '0;
      out_ready = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_sum", 32'(out_sum), 32'd0);
      chk("rst_q", 32'(out_q), 32'd0);
      chk("rst_ready", 32'(in_ready), 32'd1);

      wq = '{100, 200, 300};         run_window(24'h0, 1'b1, 0);
      wq = '{16'h00FF};              run_window(24'h000100, 1'b1, 0);
      wq = '{16'hFFFF, 16'h0001};    run_window(24'hFFFF00, 1'b1, 0);
      wq = '{16'h8000, 16'h8000};    run_window(24'h0, 1'b1, 0);
      for (int i = 0; i < MAX_LEN; i++) wq.push_back(1);
      run_window(24'h0, 1'b0, 3);
      for (int i = 0; i < MAX_LEN; i++) wq.push_back(1);
      run_window(24'h0, 1'b1, 0);
      wq = '{16'h1234, 16'h0567, 16'h0FFF};
      run_window(24'h00ABCD, 1'b1, 5);

      // Reset mid-window: partial sum and pending result are dropped.
      drive_beat(16'd50, 1'b0, 24'd10);
      drive_beat(16'd60, 1'b0, 24'd0);
      in_valid = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_ready", 32'(in_ready), 32'd1);
      tick();
      chk("mid_rst_valid2", 32'(out_valid), 32'd0);
      wq = '{7};
      run_window(24'd1000, 1'b1, 0);

      for (int w = 0; w < 40; w++) begin
         n = $urandom_range(1, MAX_LEN);
         for (int i = 0; i < n; i++) wq.push_back($urandom_range(0, 16'hFFFF));
         b = ($urandom_range(0, 1) == 1) ? 24'($urandom) : 24'($urandom_range(0, 4095));
         run_window(b, !(n == MAX_LEN && $urandom_range(0, 1) == 1), $urandom_range(0, 3));
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
